// File: rtl/vga_serial_pkg.sv
// vga_serial_pkg
// Shared definitions for the serial frame-buffer path (uart_ram_writer and
// its byte_packer): FSM state type, default frame geometry and the default
// idle timeout.
package vga_serial_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam int H_RES           = 1024;
  localparam int V_RES           = 768;
  localparam int BYTES_PER_PIXEL = 3;

  // Total bits in one frame; RAM depth is this divided by the word width.
  localparam int FRAME_BITS = H_RES * V_RES * BYTES_PER_PIXEL * 8;

  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

  function automatic int bytes_per_word(input int ram_width);
    return ram_width / 8;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer
// Collects bytes into a RAM_WIDTH-bit word. Lane k holds bits [8k+7:8k], so
// the first byte of a word lands in the LSBs.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        discard the partial word and restart at lane 0
//   load         store byte_in into the current lane this cycle
//   byte_in      byte to store
//   packed_word  partial word with byte_in merged into the current lane
//                (the complete word when word_full is high)
//   word_full    load is storing the final lane of the word
module byte_packer
  import vga_serial_pkg::*;
#(
  parameter int RAM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [7:0]           byte_in,
  output logic [RAM_WIDTH-1:0] packed_word,
  output logic                 word_full
);

  localparam int BYTES_PER_WORD = bytes_per_word(RAM_WIDTH);
  localparam int LANE_BITS      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(BYTES_PER_WORD - 1);

  logic [LANE_BITS-1:0] lane;
  logic [RAM_WIDTH-1:0] partial;

  // Merge the incoming byte into its lane so the caller can capture the
  // finished word on the same edge that stores the last byte.
  always_comb begin
    packed_word = partial;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (lane == LANE_BITS'(k)) begin
        packed_word[8*k +: 8] = byte_in;
      end
    end
  end

  assign word_full = load && (lane == LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane    <= '0;
      partial <= '0;
    end else if (load) begin
      partial <= packed_word;
      lane    <= word_full ? '0 : lane + 1'b1;
    end
  end

endmodule

// File: rtl/uart_ram_writer.sv
// uart_ram_writer
// Packs bytes from uart_rx into RAM_WIDTH-bit words and writes them to
// consecutive frame-buffer addresses from 0 to RAM_DEPTH-1, pulsing
// frame_done after the last word and wrapping back to address 0.
// Optional feature: define UART_RAM_WRITER_TIMEOUT_EN to discard a partial
// frame after TIMEOUT_CYCLES idle cycles (frame_abort pulses). Without it the
// block waits indefinitely and frame_abort is tied low.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_data       received byte, valid while rx_ready is high
//   rx_ready      one-cycle byte strobe
//   address       RAM write address
//   write_data    RAM write data (holds between writes)
//   write_enable  one-cycle write strobe per word
//   frame_done    one-cycle pulse after the last word of a frame
//   frame_abort   one-cycle pulse when a partial frame is discarded
//   overrun       sticky: a byte arrived while a write was in progress
//   busy          a frame is partially received
module uart_ram_writer
  import vga_serial_pkg::*;
#(
  parameter  int RAM_WIDTH      = 8,
  parameter  int RAM_DEPTH      = FRAME_BITS / RAM_WIDTH,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int ADDR_BITS      = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic [ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0] write_data,
  output logic                 write_enable,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_DEPTH - 1);

  state_t state, state_next;

  logic                 packer_load;
  logic                 word_full;
  logic                 timeout_expire;
  logic [RAM_WIDTH-1:0] packed_word;

  // Bytes are only taken while gathering a word; in WRITE/DONE they drop.
  assign packer_load = rx_ready && ((state == IDLE) || (state == COLLECT));

  byte_packer #(
    .RAM_WIDTH(RAM_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timeout_expire),
    .load       (packer_load),
    .byte_in    (rx_data),
    .packed_word(packed_word),
    .word_full  (word_full)
  );

`ifdef UART_RAM_WRITER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] timeout_count;
  logic        abort_pulse;

  // A byte in the expiry cycle wins: expiry requires rx_ready low.
  assign timeout_expire = (state == COLLECT) && !rx_ready && (timeout_count == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_count <= '0;
      abort_pulse   <= 1'b0;
    end else begin
      abort_pulse <= timeout_expire;
      if ((state != COLLECT) || rx_ready || timeout_expire) begin
        timeout_count <= '0;
      end else if (timeout_count != 32'hFFFF_FFFF) begin
        timeout_count <= timeout_count + 32'd1;
      end
    end
  end

  assign frame_abort = abort_pulse;
`else
  assign timeout_expire = 1'b0;
  assign frame_abort    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // With one byte per word the first byte already fills the word, so IDLE
  // goes straight to WRITE through the same word_full test.
  always_comb begin
    state_next   = state;
    write_enable = 1'b0;
    frame_done   = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (rx_ready) begin
          state_next = word_full ? WRITE : COLLECT;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        if (word_full) begin
          state_next = WRITE;
        end else if (timeout_expire) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        busy         = 1'b1;
        write_enable = 1'b1;
        state_next   = (address == LAST_ADDR) ? DONE : COLLECT;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // write_data is captured only when a word completes so it stays stable
  // through WRITE and holds until the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      address    <= '0;
      write_data <= '0;
      overrun    <= 1'b0;
    end else begin
      if (word_full) begin
        write_data <= packed_word;
      end
      if (timeout_expire) begin
        address <= '0;
      end else if (state == WRITE) begin
        address <= (address == LAST_ADDR) ? '0 : address + 1'b1;
      end
      if (rx_ready && ((state == WRITE) || (state == DONE))) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_ram_writer.sv
// tb_uart_ram_writer
// Scoreboard bench: a word-level model predicts each RAM write (address,
// data, cycle) and each frame_done cycle as bytes are issued; a monitor pops
// and compares whenever the DUT strobes. A second instance covers the
// one-byte-per-word configuration.
module tb_uart_ram_writer;

  localparam int BPW   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [1:0]  address;
  logic [15:0] write_data;
  logic        write_enable, frame_done, frame_abort, overrun, busy;

  logic [7:0]  b_rx_data = 8'h00;
  logic        b_rx_ready = 1'b0;
  logic [0:0]  b_address;
  logic [7:0]  b_write_data;
  logic        b_write_enable, b_frame_done, b_frame_abort, b_overrun, b_busy;

  always #5 clk = ~clk;

  uart_ram_writer #(.RAM_WIDTH(16), .RAM_DEPTH(DEPTH), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .address(address), .write_data(write_data), .write_enable(write_enable),
    .frame_done(frame_done), .frame_abort(frame_abort), .overrun(overrun), .busy(busy)
  );

  uart_ram_writer #(.RAM_WIDTH(8), .RAM_DEPTH(2), .TIMEOUT_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .rx_data(b_rx_data), .rx_ready(b_rx_ready),
    .address(b_address), .write_data(b_write_data), .write_enable(b_write_enable),
    .frame_done(b_frame_done), .frame_abort(b_frame_abort), .overrun(b_overrun), .busy(b_busy)
  );

  typedef struct {
    int unsigned addr;
    logic [15:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned done_q[$];
  wr_t         mon_w;
  int unsigned cyc = 0;
  int          n_compared = 0;
  int          n_mism = 0;
  bit          addr_check_next = 0;
  bit          abort_expected = 0;
  bit          abort_seen = 0;

  // Model state: bytes gathered in the current word, next address, last edge
  // at which an arriving byte is dropped, sticky overrun.
  int unsigned m_lane = 0;
  int unsigned m_addr = 0;
  int unsigned m_blocked = 0;
  logic [15:0] m_word = '0;
  bit          m_overrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mism++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic model_clear();
    m_lane = 0;
    m_addr = 0;
    m_word = '0;
    m_blocked = 0;
    m_overrun = 0;
    exp_q.delete();
    done_q.delete();
  endtask

  // Issues one byte strobe (starting 1 ns after an edge), records the
  // model's prediction, then idles for gap cycles. gap=0 gives back-to-back
  // strobes on consecutive edges.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int unsigned e;
    e = cyc + 1;
    rx_data  = b;
    rx_ready = 1'b1;
    if (e <= m_blocked) begin
      m_overrun = 1;
    end else begin
      m_word = m_word | (16'(b) << (8 * m_lane));
      m_lane++;
      if (m_lane == BPW) begin
        exp_q.push_back('{m_addr, m_word, e});
        if (m_addr == DEPTH - 1) begin
          done_q.push_back(e + 1);
          m_blocked = e + 2;
          m_addr = 0;
        end else begin
          m_blocked = e + 1;
          m_addr++;
        end
        m_lane = 0;
        m_word = '0;
      end
    end
    @(posedge clk); #1;
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drain the scoreboard, compare quiet-point status, then reset.
  task automatic finish_phase(input string name);
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0 && done_q.size() == 0) break;
      @(posedge clk); #1;
    end
    checkOutput({name, "_pending_writes"}, exp_q.size(), 0);
    checkOutput({name, "_pending_done"}, done_q.size(), 0);
    checkOutput({name, "_overrun"}, overrun, m_overrun);
    checkOutput({name, "_busy"}, busy, (m_addr != 0 || m_lane != 0));
    checkOutput({name, "_address"}, address, m_addr);
    applyReset();
    checkOutput({name, "_rst_overrun"}, overrun, 0);
    checkOutput({name, "_rst_busy"}, busy, 0);
    checkOutput({name, "_rst_address"}, address, 0);
  endtask

  // Monitor: every strobe from the DUT is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mism++;
          $display("[TB] FAIL unexpected_write: addr=%0d data=%h, expected no write (cycle %0d)", address, write_data, cyc);
        end else begin
          mon_w = exp_q.pop_front();
          checkOutput("write_addr", 32'(address), mon_w.addr);
          checkOutput("write_data", 32'(write_data), 32'(mon_w.data));
          checkOutput("write_cycle", cyc, mon_w.cyc);
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) begin
          n_compared++;
          n_mism++;
          $display("[TB] FAIL unexpected_frame_done: frame_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          checkOutput("frame_done_cycle", cyc, done_q.pop_front());
        end
        addr_check_next = 1;
      end else if (addr_check_next) begin
        checkOutput("address_after_done", 32'(address), 0);
        addr_check_next = 0;
      end
      if (frame_abort) begin
        if (!abort_expected) begin
          n_compared++;
          n_mism++;
          $display("[TB] FAIL unexpected_abort: frame_abort=1 expected 0 (cycle %0d)", cyc);
        end else begin
          abort_seen = 1;
          checkOutput("abort_busy", busy, 0);
          checkOutput("abort_address", 32'(address), 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of both instances.
    checkOutput("rst_address", address, 0);
    checkOutput("rst_write_data", write_data, 0);
    checkOutput("rst_write_enable", write_enable, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_abort", frame_abort, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("b_rst_write_enable", b_write_enable, 0);
    checkOutput("b_rst_busy", b_busy, 0);

    // Frame of 0x11..0x88 spaced five cycles apart, then a second frame.
    $display("[TB] phase: two frames");
    applyStimulus(8'h11, 4);
    checkOutput("busy_mid_word", busy, 1);
    for (int i = 2; i <= 8; i++) applyStimulus(8'(i * 8'h11), 4);
    checkOutput("busy_after_frame", busy, 0);
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom), 4);
    checkOutput("overrun_after_two_frames", overrun, 0);
    finish_phase("frames");

    // Random bytes with random spacing, including back-to-back strobes.
    $display("[TB] phase: random");
    for (int i = 0; i < 40; i++) applyStimulus(8'($urandom), $urandom_range(0, 3));
    finish_phase("random");

    // Third byte in consecutive cycles lands in WRITE and is dropped.
    $display("[TB] phase: overrun");
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    applyStimulus(8'hCC, 3);
    checkOutput("overrun_set", overrun, 1);
    applyStimulus(8'h12, 2);
    applyStimulus(8'h34, 2);
    checkOutput("overrun_sticky", overrun, 1);
    finish_phase("overrun");

    // Reset with a half-filled word; 0x55 must never be written.
    $display("[TB] phase: reset mid-word");
    applyStimulus(8'h55, 2);
    applyReset();
    applyStimulus(8'h01, 4);
    applyStimulus(8'h02, 4);
    finish_phase("midword");

`ifdef UART_RAM_WRITER_TIMEOUT_EN
    $display("[TB] phase: timeout");
    applyStimulus(8'h31, 4);
    applyStimulus(8'h32, 4);
    abort_expected = 1;
    abort_seen = 0;
    applyStimulus(8'h33, 0);
    for (int i = 0; i < 60 && !abort_seen; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("abort_seen", abort_seen, 1);
    abort_expected = 0;
    m_lane = 0;
    m_word = '0;
    m_addr = 0;
    applyStimulus(8'h34, 4);
    applyStimulus(8'h35, 4);
    finish_phase("timeout");
`endif

    // One byte per word: the write follows the strobe directly.
    $display("[TB] phase: 8-bit words");
    b_rx_data = 8'h5A;
    b_rx_ready = 1'b1;
    @(posedge clk); #1;
    b_rx_ready = 1'b0;
    checkOutput("b_we_first", b_write_enable, 1);
    checkOutput("b_addr_first", b_address, 0);
    checkOutput("b_data_first", b_write_data, 8'h5A);
    @(posedge clk); #1;
    checkOutput("b_we_idle", b_write_enable, 0);
    b_rx_data = 8'hA5;
    b_rx_ready = 1'b1;
    @(posedge clk); #1;
    b_rx_ready = 1'b0;
    checkOutput("b_we_second", b_write_enable, 1);
    checkOutput("b_addr_second", b_address, 1);
    checkOutput("b_data_second", b_write_data, 8'hA5);
    @(posedge clk); #1;
    checkOutput("b_frame_done", b_frame_done, 1);
    @(posedge clk); #1;
    checkOutput("b_frame_done_clear", b_frame_done, 0);
    checkOutput("b_address_wrap", b_address, 0);
    checkOutput("b_data_hold", b_write_data, 8'hA5);
    checkOutput("b_overrun", b_overrun, 0);
    checkOutput("b_busy", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mism);
    $finish;
  end

endmodule
